// File: rtl/note_sequencer.sv
// Note sequencer: walks note indices, times sound/gap phases from the duration ROM, and emits gate/strobe outputs.
// Optional articulation gap enabled by defining NOTE_SEQ_ARTICULATION_EN; otherwise notes play legato.
module note_sequencer #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int NUM_NOTES  = 29,
  parameter int GAP_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        loop_en,
  input  logic [28:0] note_dur,
  output logic [10:0] note_index,
  output logic        note_on,
  output logic        note_start,
  output logic        song_done,
  output logic        busy
);

  if (CLOCK_FREQ < 1 || NUM_NOTES < 1 || NUM_NOTES > 2048 ||
      GAP_CYCLES < 0 || GAP_CYCLES > 29'h1FFF_FFFF) begin : g_bad_param
    $error("note_sequencer: parameter out of range");
  end

  localparam logic [10:0] LAST_IDX = 11'(NUM_NOTES - 1);

`ifdef NOTE_SEQ_ARTICULATION_EN
  localparam logic [28:0] GAP_C = 29'(GAP_CYCLES);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NOTE} state_e;
`endif

  state_e      state_q, state_d;
  logic [28:0] cnt_q, cnt_d;
  logic [10:0] note_index_q, note_index_d;
  logic        note_on_q, note_on_d;
  logic        note_start_q, note_start_d;
  logic        song_done_q, song_done_d;
  logic        busy_q, busy_d;
  logic        advance;
  logic [28:0] dur_eff;
`ifdef NOTE_SEQ_ARTICULATION_EN
  logic [28:0] gap_q, gap_d;
`endif

  // A zero duration still plays for one cycle so every note is audible.
  assign dur_eff = (note_dur == 29'd0) ? 29'd1 : note_dur;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    note_index_d = note_index_q;
    note_on_d    = 1'b0;
    note_start_d = 1'b0;
    song_done_d  = 1'b0;
    advance      = 1'b0;
`ifdef NOTE_SEQ_ARTICULATION_EN
    gap_d        = gap_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD;
          note_index_d = 11'd0;
        end
      end
      S_LOAD: begin
`ifdef NOTE_SEQ_ARTICULATION_EN
        if (dur_eff > GAP_C) begin
          cnt_d = dur_eff - GAP_C;
          gap_d = GAP_C;
        end else begin
          cnt_d = dur_eff;
          gap_d = 29'd0;
        end
`else
        cnt_d = dur_eff;
`endif
        state_d      = S_NOTE;
        note_on_d    = 1'b1;
        note_start_d = 1'b1;
      end
      S_NOTE: begin
        // While paused the counter and state hold and the gate stays low.
        if (!pause) begin
          if (cnt_q <= 29'd1) begin
`ifdef NOTE_SEQ_ARTICULATION_EN
            if (gap_q != 29'd0) begin
              cnt_d   = gap_q;
              state_d = S_GAP;
            end else begin
              advance = 1'b1;
            end
`else
            advance = 1'b1;
`endif
          end else begin
            cnt_d     = cnt_q - 29'd1;
            note_on_d = 1'b1;
          end
        end
      end
`ifdef NOTE_SEQ_ARTICULATION_EN
      S_GAP: begin
        if (!pause) begin
          if (cnt_q <= 29'd1) begin
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q - 29'd1;
          end
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // End of a note: the next-note decision happens in the same cycle, no dwell state.
    if (advance) begin
      if (note_index_q < LAST_IDX) begin
        note_index_d = note_index_q + 11'd1;
        state_d      = S_LOAD;
      end else if (loop_en) begin
        note_index_d = 11'd0;
        state_d      = S_LOAD;
      end else begin
        note_index_d = 11'd0;
        song_done_d  = 1'b1;
        state_d      = S_IDLE;
      end
    end

    if (stop) begin
      state_d      = S_IDLE;
      note_index_d = 11'd0;
      cnt_d        = 29'd0;
      note_on_d    = 1'b0;
      note_start_d = 1'b0;
      song_done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 29'd0;
      note_index_q <= 11'd0;
      note_on_q    <= 1'b0;
      note_start_q <= 1'b0;
      song_done_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef NOTE_SEQ_ARTICULATION_EN
      gap_q        <= 29'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      note_index_q <= note_index_d;
      note_on_q    <= note_on_d;
      note_start_q <= note_start_d;
      song_done_q  <= song_done_d;
      busy_q       <= busy_d;
`ifdef NOTE_SEQ_ARTICULATION_EN
      gap_q        <= gap_d;
`endif
    end
  end

  assign note_index = note_index_q;
  assign note_on    = note_on_q;
  assign note_start = note_start_q;
  assign song_done  = song_done_q;
  assign busy       = busy_q;

endmodule
